// File: rtl/sdm_dac_sequencer.sv
// Sample scheduler feeding a first-order sigma-delta DAC modulator: buffers samples
// in a small FIFO and presents one code per oversampling period, with prime/underrun/shutdown handling.
`timescale 1ns/1ps
module sdm_dac_sequencer #(
   parameter int            DW    = 12,
   parameter int            DEPTH = 4,
   parameter int            CW    = 10,
   parameter logic [DW-1:0] MID   = 12'h800
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [CW-1:0]                osr,
   input  logic                         s_valid,
   input  logic [DW-1:0]                s_data,
   output logic                         s_ready,
   output logic [DW-1:0]                dac_code,
   output logic                         mod_rst,
   output logic                         sample_tick,
   output logic                         underrun,
   input  logic                         clr_underrun,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   count_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   osr_q, osr_d;
   logic [DW-1:0]   dac_code_q, dac_code_d;
   logic            mod_rst_q, mod_rst_d;
   logic            underrun_q, underrun_d;

   logic            full, empty, push, pop, flush, boundary;
   logic [DW-1:0]   head;

   assign full     = (count_q == LW'(DEPTH));
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];
   assign boundary = (state_q == RUN) && (cnt_q == osr_q);
   // A push landing on the shutdown edge is discarded along with the flushed contents.
   assign push     = s_valid && !full && !flush;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      osr_d      = osr_q;
      dac_code_d = dac_code_q;
      mod_rst_d  = mod_rst_q;
      underrun_d = underrun_q;
      pop        = 1'b0;
      flush      = 1'b0;

      if (clr_underrun) underrun_d = 1'b0;

      case (state_q)
         IDLE: begin
            mod_rst_d  = 1'b1;
            dac_code_d = MID;
            if (en) state_d = PRIME;
         end
         PRIME: begin
            mod_rst_d = 1'b1;
            if (!en) begin
               state_d = IDLE;
            end else if (!empty) begin
               pop        = 1'b1;
               dac_code_d = head;
               osr_d      = osr;
               cnt_d      = '0;
               mod_rst_d  = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (boundary) begin
               cnt_d = '0;
               if (!en) begin
                  state_d    = IDLE;
                  dac_code_d = MID;
                  mod_rst_d  = 1'b1;
                  flush      = 1'b1;
               end else if (!empty) begin
                  pop        = 1'b1;
                  dac_code_d = head;
               end else begin
                  // Setting wins over a simultaneous clear.
                  underrun_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mod_rst_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         osr_q      <= '0;
         dac_code_q <= MID;
         mod_rst_q  <= 1'b1;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         osr_q      <= osr_d;
         dac_code_q <= dac_code_d;
         mod_rst_q  <= mod_rst_d;
         underrun_q <= underrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   assign s_ready     = !full;
   assign dac_code    = dac_code_q;
   assign mod_rst     = mod_rst_q;
   assign sample_tick = boundary;
   assign underrun    = underrun_q;
   assign level       = count_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sdm_dac_sequencer.sv
// Directed bench for sdm_dac_sequencer: expected codes are queued as samples are
// pushed and popped when the DUT is due to load them.
`timescale 1ns/1ps
module tb_sdm_dac_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [9:0]  osr = '0;
   logic        s_valid = 1'b0;
   logic [11:0] s_data = '0;
   logic        s_ready;
   logic [11:0] dac_code;
   logic        mod_rst;
   logic        sample_tick;
   logic        underrun;
   logic        clr_underrun = 1'b0;
   logic [2:0]  level;
   logic        busy;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [11:0] sb[$];
   logic [11:0] cur = 12'h800;

   sdm_dac_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .osr(osr),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .dac_code(dac_code), .mod_rst(mod_rst), .sample_tick(sample_tick),
      .underrun(underrun), .clr_underrun(clr_underrun),
      .level(level), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic exp_code(string tag);
      logic [11:0] e;
      if (sb.size() == 0) begin
         n_chk++;
         $error("FAIL %s: scoreboard empty, observed 0x%0h", tag, dac_code);
      end else begin
         e   = sb.pop_front();
         cur = e;
         chk(tag, 32'(dac_code), 32'(e));
      end
   endtask

   task automatic push(logic [11:0] d);
      s_valid = 1'b1;
      s_data  = d;
      sb.push_back(d);
      step();
      s_valid = 1'b0;
   endtask

   // n cycles with the current code held; sample_tick only on the last one if tick_last.
   task automatic hold(string tag, int n, bit tick_last);
      for (int k = 0; k < n; k++) begin
         chk({tag, "_hold"}, 32'(dac_code), 32'(cur));
         chk({tag, "_tick"}, 32'(sample_tick), 32'(tick_last && (k == n - 1)));
         step();
      end
   endtask

   task automatic expect_idle(string tag);
      cur = 12'h800;
      chk({tag, "_dac"},     32'(dac_code), 32'h800);
      chk({tag, "_mod_rst"}, 32'(mod_rst),  32'd1);
      chk({tag, "_busy"},    32'(busy),     32'd0);
      chk({tag, "_level"},   32'(level),    32'd0);
   endtask

   task automatic check_reset(string tag);
      expect_idle(tag);
      chk({tag, "_tick"},     32'(sample_tick), 32'd0);
      chk({tag, "_underrun"}, 32'(underrun),    32'd0);
      chk({tag, "_s_ready"},  32'(s_ready),     32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit tick_seen;

      // reset and idle
      step(); step();
      rst = 1'b0;
      check_reset("reset");
      tick_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sample_tick) tick_seen = 1'b1;
      end
      chk("idle_no_tick", 32'(tick_seen), 32'd0);
      check_reset("idle20");

      // basic run, osr=3, then underrun on the empty FIFO and shutdown
      push(12'h100); push(12'h200); push(12'h300);
      chk("basic_level", 32'(level), 32'd3);
      osr = 10'd3;
      en  = 1'b1;
      step();
      chk("basic_prime_busy", 32'(busy), 32'd1);
      chk("basic_prime_mrst", 32'(mod_rst), 32'd1);
      step();
      chk("basic_run_mrst", 32'(mod_rst), 32'd0);
      exp_code("basic_c0");
      hold("basic_p0", 4, 1'b1);
      exp_code("basic_c1");
      hold("basic_p1", 4, 1'b1);
      exp_code("basic_c2");
      hold("basic_p2", 4, 1'b1);
      chk("basic_underrun", 32'(underrun), 32'd1);
      chk("basic_underrun_hold", 32'(dac_code), 32'(cur));
      en = 1'b0;
      hold("basic_p3", 4, 1'b1);
      expect_idle("basic_off");
      chk("basic_sticky", 32'(underrun), 32'd1);
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("basic_clr", 32'(underrun), 32'd0);

      // underrun with osr=1, late push, clear vs set priority
      osr = 10'd1;
      push(12'hAAA);
      en = 1'b1;
      step();
      chk("ur_prime_mrst", 32'(mod_rst), 32'd1);
      step();
      exp_code("ur_c0");
      hold("ur_p0", 2, 1'b1);
      chk("ur_flag", 32'(underrun), 32'd1);
      chk("ur_code_hold", 32'(dac_code), 32'hAAA);
      push(12'hBBB);
      chk("ur_late_tick", 32'(sample_tick), 32'd1);
      step();
      exp_code("ur_late_load");
      clr_underrun = 1'b1;
      step();
      chk("ur_clr_alone", 32'(underrun), 32'd0);
      chk("ur_tick2", 32'(sample_tick), 32'd1);
      step();
      clr_underrun = 1'b0;
      chk("ur_set_wins", 32'(underrun), 32'd1);
      chk("ur_hold_bbb", 32'(dac_code), 32'hBBB);
      en = 1'b0;
      hold("ur_p2", 2, 1'b1);
      expect_idle("ur_off");
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("ur_clr_final", 32'(underrun), 32'd0);

      // backpressure: five back-to-back pushes into a 4-deep FIFO
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready", 32'(s_ready), 32'(i < 4));
         s_valid = 1'b1;
         s_data  = 12'hC00 + 12'(i);
         if (i < 4) sb.push_back(s_data);
         step();
      end
      chk("bp_level_full", 32'(level), 32'd4);
      chk("bp_ready_full", 32'(s_ready), 32'd0);
      osr = 10'd2;
      en  = 1'b1;
      step();
      chk("bp_prime_level", 32'(level), 32'd4);
      step();
      exp_code("bp_c0");
      chk("bp_level_pop", 32'(level), 32'd3);
      chk("bp_ready_pop", 32'(s_ready), 32'd1);
      sb.push_back(12'hC04);
      step();
      s_valid = 1'b0;
      chk("bp_fifth_in", 32'(level), 32'd4);
      hold("bp_p0", 2, 1'b1);
      exp_code("bp_c1");
      hold("bp_p1", 3, 1'b1);
      exp_code("bp_c2");
      hold("bp_p2", 3, 1'b1);
      exp_code("bp_c3");
      hold("bp_p3", 3, 1'b1);
      exp_code("bp_c4");
      en = 1'b0;
      hold("bp_p4", 3, 1'b1);
      expect_idle("bp_off");

      // shutdown mid-period with osr=7; osr change mid-RUN ignored
      push(12'hD01); push(12'hD02); push(12'hD03);
      osr = 10'd7;
      en  = 1'b1;
      step(); step();
      exp_code("sd_c0");
      osr = 10'd2;
      hold("sd_p0", 8, 1'b1);
      exp_code("sd_c1");
      hold("sd_p1a", 2, 1'b0);
      en = 1'b0;
      hold("sd_p1b", 5, 1'b0);
      s_valid = 1'b1;
      s_data  = 12'hEEE;
      hold("sd_p1c", 1, 1'b1);
      s_valid = 1'b0;
      expect_idle("sd_off");
      sb.delete();

      // osr=0 with a push every cycle
      push(12'h0F0); push(12'h0F1);
      osr     = 10'd0;
      en      = 1'b1;
      s_valid = 1'b1;
      s_data  = 12'h0F2;
      sb.push_back(s_data);
      step();
      s_data = 12'h0F3;
      sb.push_back(s_data);
      step();
      exp_code("os0_c0");
      chk("os0_level0", 32'(level), 32'd3);
      for (int k = 4; k < 10; k++) begin
         chk("os0_tick", 32'(sample_tick), 32'd1);
         s_data = 12'h0F0 + 12'(k);
         sb.push_back(s_data);
         step();
         exp_code("os0_code");
         chk("os0_level", 32'(level), 32'd3);
      end
      s_valid = 1'b0;
      en      = 1'b0;
      chk("os0_last_tick", 32'(sample_tick), 32'd1);
      step();
      expect_idle("os0_off");
      sb.delete();

      // reset during RUN
      osr = 10'd5;
      push(12'h123);
      en = 1'b1;
      step(); step();
      exp_code("rr_c0");
      push(12'h456);
      chk("rr_level", 32'(level), 32'd1);
      rst = 1'b1;
      en  = 1'b0;
      step();
      rst = 1'b0;
      check_reset("rr_reset");
      step();
      chk("rr_stay_idle", 32'(busy), 32'd0);
      sb.delete();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
